// File: rtl/sfp_rx_deframer.sv
// Receive deframer for the SFP link: lock on K28.5 idles, delimit SOF/EOF frames, check XOR checksum, feed the RX FIFO.
// Optional SOF sequence-number checking is built when SFP_RX_SEQ_CHECK_EN is defined.
module sfp_rx_deframer #(
    parameter int MAX_WORDS    = 256,
    parameter int LOCK_COUNT   = 8,
    parameter int LOSS_TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [63:0] rx_parallel_data,
    input  logic        rx_std_pcfifo_empty,
    input  logic        rx_std_pcfifo_full,
    input  logic        out_full,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_eof,
    output logic        out_err,
    output logic        link_up,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`ifdef SFP_RX_SEQ_CHECK_EN
    ,
    output logic [15:0] seq_err_cnt
`endif
);

    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);
    localparam int WCNT_W = $clog2(MAX_WORDS + 1);

    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [7:0] K_SOF  = 8'hFB;
    localparam logic [7:0] K_EOF  = 8'hFD;

    typedef enum logic [1:0] {HUNT, PAYLOAD, DROP} state_t;

    logic              raw_valid;
    logic              raw_idle;
    logic              raw_sof;
    logic              unused_bits;

    logic              link_q;
    logic              loss_q;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOSS_W-1:0] loss_timer;

    logic              in_valid;
    logic [7:0]        in_lo;
    logic [7:0]        in_hi;
    logic              in_lo_k;
    logic              in_hi_k;
    logic              in_idle;
    logic              in_sof;
    logic              in_eof;
    logic              in_data;
    logic              in_badk;

    state_t            state;
    state_t            state_n;
    logic [7:0]        csum;
    logic [7:0]        csum_n;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_n;

    logic              hold_valid;
    logic              hold_valid_n;
    logic [15:0]       hold_data;
    logic [15:0]       hold_data_n;
    logic              hold_err;
    logic              hold_err_n;

    logic              req_valid;
    logic              req_eof;
    logic              req_err;
    logic [15:0]       req_data;
    logic              emit_hold;
    logic              emit_req;
    logic              start;
    logic              abort;
    logic              good_inc;
    logic              bad_inc;
    logic              seq_flag;

`ifdef SFP_RX_SEQ_CHECK_EN
    logic              seq_bad;
    logic              seq_bad_n;
    logic              seq_armed;
    logic              seq_armed_n;
    logic [7:0]        last_seq;
    logic [7:0]        last_seq_n;
    logic              seq_inc;

    assign seq_flag = seq_bad;
`else
    assign seq_flag = 1'b0;
`endif

    assign raw_valid   = ~rx_std_pcfifo_empty;
    assign raw_idle    = raw_valid & rx_parallel_data[8] & (rx_parallel_data[7:0] == K_IDLE);
    assign raw_sof     = raw_valid & rx_parallel_data[8] & (rx_parallel_data[7:0] == K_SOF);
    assign unused_bits = ^{rx_parallel_data[63:25], rx_parallel_data[15:9]};

    // A PCS overflow drops the link combinationally in the cycle it is flagged.
    assign link_up = link_q & ~rx_std_pcfifo_full;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_q     <= 1'b0;
            loss_q     <= 1'b0;
            lock_cnt   <= '0;
            loss_timer <= '0;
        end else if (rx_std_pcfifo_full) begin
            link_q     <= 1'b0;
            loss_q     <= link_q;
            lock_cnt   <= '0;
            loss_timer <= '0;
        end else if (!link_q) begin
            loss_q     <= 1'b0;
            loss_timer <= '0;
            if (raw_valid) begin
                if (!raw_idle) begin
                    lock_cnt <= '0;
                end else if (lock_cnt == LOCK_W'(LOCK_COUNT - 1)) begin
                    link_q   <= 1'b1;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end
        end else begin
            lock_cnt <= '0;
            if (raw_idle | raw_sof) begin
                loss_timer <= '0;
                loss_q     <= 1'b0;
            end else if (loss_timer == LOSS_W'(LOSS_TIMEOUT - 1)) begin
                link_q     <= 1'b0;
                loss_timer <= '0;
                loss_q     <= 1'b1;
            end else begin
                loss_timer <= loss_timer + 1'b1;
                loss_q     <= 1'b0;
            end
        end
    end

    // Words are registered once so the write decision sees out_full in the very cycle the write happens.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            in_valid <= 1'b0;
            in_lo    <= '0;
            in_hi    <= '0;
            in_lo_k  <= 1'b0;
            in_hi_k  <= 1'b0;
        end else begin
            in_valid <= raw_valid;
            if (raw_valid) begin
                in_lo   <= rx_parallel_data[7:0];
                in_lo_k <= rx_parallel_data[8];
                in_hi   <= rx_parallel_data[23:16];
                in_hi_k <= rx_parallel_data[24];
            end
        end
    end

    assign in_idle = in_lo_k & (in_lo == K_IDLE);
    assign in_sof  = in_lo_k & (in_lo == K_SOF);
    assign in_eof  = in_lo_k & (in_lo == K_EOF);
    assign in_data = ~in_lo_k & ~in_hi_k;
    assign in_badk = ~in_data & ~in_idle & ~in_sof & ~in_eof;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= HUNT;
            csum       <= '0;
            wcnt       <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_err   <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            csum       <= csum_n;
            wcnt       <= wcnt_n;
            hold_valid <= hold_valid_n;
            hold_data  <= hold_data_n;
            hold_err   <= hold_err_n;
            if (good_inc && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            if (bad_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

`ifdef SFP_RX_SEQ_CHECK_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            seq_bad     <= 1'b0;
            seq_armed   <= 1'b0;
            last_seq    <= '0;
            seq_err_cnt <= '0;
        end else begin
            seq_bad   <= seq_bad_n;
            seq_armed <= seq_armed_n;
            last_seq  <= last_seq_n;
            if (seq_inc && seq_err_cnt != 16'hFFFF) seq_err_cnt <= seq_err_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        state_n      = state;
        csum_n       = csum;
        wcnt_n       = wcnt;
        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        hold_err_n   = hold_err;
        req_valid    = 1'b0;
        req_eof      = 1'b0;
        req_err      = 1'b0;
        req_data     = '0;
        start        = 1'b0;
        abort        = 1'b0;
        good_inc     = 1'b0;
        bad_inc      = 1'b0;
`ifdef SFP_RX_SEQ_CHECK_EN
        seq_bad_n    = seq_bad;
        seq_armed_n  = seq_armed;
        last_seq_n   = last_seq;
        seq_inc      = 1'b0;
`endif

        if (loss_q) begin
            abort   = (state == PAYLOAD);
            state_n = HUNT;
        end else if (in_valid) begin
            case (state)
                HUNT: begin
                    start = in_sof & link_q;
                end
                PAYLOAD: begin
                    if (in_data) begin
                        if (wcnt == WCNT_W'(MAX_WORDS)) begin
                            abort   = 1'b1;
                            state_n = DROP;
                        end else begin
                            req_valid = 1'b1;
                            req_data  = {in_hi, in_lo};
                            csum_n    = csum ^ in_lo ^ in_hi;
                            wcnt_n    = wcnt + 1'b1;
                        end
                    end else if (in_eof) begin
                        req_valid = 1'b1;
                        req_eof   = 1'b1;
                        req_data  = {8'h00, in_hi};
                        req_err   = (in_hi != csum) | seq_flag;
                        good_inc  = ~req_err;
                        bad_inc   = req_err;
                        state_n   = HUNT;
                    end else if (in_sof) begin
                        abort = 1'b1;
                        start = 1'b1;
                    end else if (in_badk) begin
                        abort   = 1'b1;
                        state_n = DROP;
                    end
                end
                DROP: begin
                    if (in_eof) state_n = HUNT;
                    else start = in_sof;
                end
                default: state_n = HUNT;
            endcase
        end

        if (abort) begin
            req_valid = 1'b1;
            req_eof   = 1'b1;
            req_err   = 1'b1;
            req_data  = '0;
            bad_inc   = 1'b1;
        end

        if (start) begin
            state_n = PAYLOAD;
            csum_n  = '0;
            wcnt_n  = '0;
`ifdef SFP_RX_SEQ_CHECK_EN
            seq_bad_n   = seq_armed & (in_hi != last_seq + 8'd1);
            seq_inc     = seq_armed & (in_hi != last_seq + 8'd1);
            last_seq_n  = in_hi;
            seq_armed_n = 1'b1;
`endif
        end

`ifdef SFP_RX_SEQ_CHECK_EN
        if (!link_q) seq_armed_n = 1'b0;
`endif

        // One write per cycle: a held status word always goes first, anything else left over is blocked.
        emit_hold = hold_valid & ~out_full;
        emit_req  = req_valid & ~hold_valid & ~out_full;
        if (emit_hold) hold_valid_n = 1'b0;

        if (req_valid && !emit_req) begin
            if (!req_eof) begin
                state_n = DROP;
                bad_inc = 1'b1;
                if (!hold_valid_n) begin
                    hold_valid_n = 1'b1;
                    hold_data_n  = '0;
                    hold_err_n   = 1'b1;
                end
            end else if (!hold_valid_n) begin
                hold_valid_n = 1'b1;
                hold_data_n  = req_data;
                hold_err_n   = req_err;
            end else begin
                // No room for a second status word: the frame is lost and counted as bad.
                good_inc = 1'b0;
                bad_inc  = 1'b1;
            end
        end

        out_valid = emit_hold | emit_req;
        out_eof   = emit_hold | (emit_req & req_eof);
        out_err   = emit_hold ? hold_err : (emit_req & req_err);
        out_data  = emit_hold ? hold_data : (emit_req ? req_data : 16'h0000);
    end

endmodule

// File: tb/tb_sfp_rx_deframer.sv
// Directed self-checking bench for sfp_rx_deframer: lock, frames, aborts, backpressure, link loss, reset.
module tb_sfp_rx_deframer;

    logic        CLK;
    logic        nRST;
    logic [63:0] rx_parallel_data;
    logic        rx_std_pcfifo_empty;
    logic        rx_std_pcfifo_full;
    logic        out_full;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_eof;
    logic        out_err;
    logic        link_up;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`ifdef SFP_RX_SEQ_CHECK_EN
    logic [15:0] seq_err_cnt;
`endif

    int vectors;
    int miscompares;

    sfp_rx_deframer dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .rx_parallel_data    (rx_parallel_data),
        .rx_std_pcfifo_empty (rx_std_pcfifo_empty),
        .rx_std_pcfifo_full  (rx_std_pcfifo_full),
        .out_full            (out_full),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_eof             (out_eof),
        .out_err             (out_err),
        .link_up             (link_up),
        .frame_cnt           (frame_cnt),
        .err_cnt             (err_cnt)
`ifdef SFP_RX_SEQ_CHECK_EN
        ,
        .seq_err_cnt         (seq_err_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [63:0] w_k(input logic [7:0] code, input logic [7:0] hi);
        return {39'h0, 1'b0, hi, 7'h0, 1'b1, code};
    endfunction

    function automatic logic [63:0] w_d(input logic [7:0] hi, input logic [7:0] lo);
        return {39'h0, 1'b0, hi, 7'h0, 1'b0, lo};
    endfunction

    // Word presented before a rising edge; out_full applied for the cycle after it, outputs sampled then.
    task automatic apply_stimulus(input logic [63:0] word, input logic full);
        @(negedge CLK);
        rx_parallel_data    = word;
        rx_std_pcfifo_empty = 1'b0;
        @(posedge CLK);
        #1;
        out_full = full;
        #1;
    endtask

    task automatic apply_gap(input logic full);
        @(negedge CLK);
        rx_std_pcfifo_empty = 1'b1;
        @(posedge CLK);
        #1;
        out_full = full;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic v, input logic e, input logic r,
                                input logic [15:0] d);
        logic [18:0] obs;
        logic [18:0] exp;
        obs = {out_valid, (out_valid ? {out_eof, out_err, out_data} : 18'h0)};
        exp = {v, (v ? {e, r, d} : 18'h0)};
        chk(tag, {13'h0, obs}, {13'h0, exp});
    endtask

    logic [63:0] idle_w;

    initial begin
        vectors             = 0;
        miscompares         = 0;
        nRST                = 1'b0;
        rx_parallel_data    = '0;
        rx_std_pcfifo_empty = 1'b1;
        rx_std_pcfifo_full  = 1'b0;
        out_full            = 1'b0;
        idle_w              = w_k(8'hBC, 8'h00);

        repeat (3) @(posedge CLK);
        #1;
        check_output("reset_out", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("reset_link", {31'h0, link_up}, 32'h0);
        chk("reset_frame_cnt", {16'h0, frame_cnt}, 32'h0);
        chk("reset_err_cnt", {16'h0, err_cnt}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Broken idle run must not lock; the eighth consecutive idle must.
        repeat (7) apply_stimulus(idle_w, 1'b0);
        apply_stimulus(w_d(8'h00, 8'h00), 1'b0);
        check_output("hunt_data_ignored", 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (7) apply_stimulus(idle_w, 1'b0);
        chk("lock_after_7", {31'h0, link_up}, 32'h0);
        apply_stimulus(idle_w, 1'b0);
        chk("lock_after_8", {31'h0, link_up}, 32'h1);

        // Good frame: checksum 12^34^56^78 = 08.
        apply_stimulus(w_k(8'hFB, 8'h01), 1'b0);
        check_output("f1_sof", 1'b0, 1'b0, 1'b0, 16'h0);
        apply_stimulus(w_d(8'h12, 8'h34), 1'b0);
        check_output("f1_d0", 1'b1, 1'b0, 1'b0, 16'h1234);
        apply_stimulus(w_d(8'h56, 8'h78), 1'b0);
        check_output("f1_d1", 1'b1, 1'b0, 1'b0, 16'h5678);
        apply_stimulus(w_k(8'hFD, 8'h08), 1'b0);
        check_output("f1_status", 1'b1, 1'b1, 1'b0, 16'h0008);
        apply_gap(1'b0);
        chk("f1_frame_cnt", {16'h0, frame_cnt}, 32'd1);

        // Bad checksum.
        apply_stimulus(w_k(8'hFB, 8'h02), 1'b0);
        apply_stimulus(w_d(8'h12, 8'h34), 1'b0);
        apply_stimulus(w_d(8'h56, 8'h78), 1'b0);
        apply_stimulus(w_k(8'hFD, 8'h09), 1'b0);
        check_output("f2_status", 1'b1, 1'b1, 1'b1, 16'h0009);
        apply_gap(1'b0);
        chk("f2_err_cnt", {16'h0, err_cnt}, 32'd1);
        chk("f2_frame_cnt", {16'h0, frame_cnt}, 32'd1);

        // SOF inside a frame aborts it and starts a new one: checksum 11^22 = 33.
        apply_stimulus(w_k(8'hFB, 8'h03), 1'b0);
        apply_stimulus(w_d(8'hAA, 8'h55), 1'b0);
        apply_stimulus(w_d(8'h01, 8'h02), 1'b0);
        apply_stimulus(w_k(8'hFB, 8'h04), 1'b0);
        check_output("f3_abort", 1'b1, 1'b1, 1'b1, 16'h0000);
        apply_stimulus(w_d(8'h11, 8'h22), 1'b0);
        check_output("f3_d0", 1'b1, 1'b0, 1'b0, 16'h1122);
        apply_stimulus(w_k(8'hFD, 8'h33), 1'b0);
        check_output("f3_status", 1'b1, 1'b1, 1'b0, 16'h0033);
        apply_gap(1'b0);
        chk("f3_counts", {frame_cnt, err_cnt}, {16'd2, 16'd2});

        // Payload word blocked by out_full: dropped, single abort later, EOF ignored.
        apply_stimulus(w_k(8'hFB, 8'h05), 1'b0);
        apply_stimulus(w_d(8'h01, 8'h01), 1'b0);
        check_output("f4_d0", 1'b1, 1'b0, 1'b0, 16'h0101);
        apply_stimulus(w_d(8'h02, 8'h02), 1'b1);
        check_output("f4_blocked", 1'b0, 1'b0, 1'b0, 16'h0);
        apply_stimulus(w_d(8'h03, 8'h03), 1'b0);
        check_output("f4_abort", 1'b1, 1'b1, 1'b1, 16'h0000);
        apply_stimulus(w_k(8'hFD, 8'h00), 1'b0);
        check_output("f4_eof_ignored", 1'b0, 1'b0, 1'b0, 16'h0);
        apply_gap(1'b0);
        chk("f4_counts", {frame_cnt, err_cnt}, {16'd2, 16'd3});
        apply_stimulus(w_d(8'h44, 8'h44), 1'b0);
        check_output("f4_back_in_hunt", 1'b0, 1'b0, 1'b0, 16'h0);

        // Next frame is clean again: checksum 0A^0B = 01.
        apply_stimulus(w_k(8'hFB, 8'h06), 1'b0);
        apply_stimulus(w_d(8'h0A, 8'h0B), 1'b0);
        check_output("f5_d0", 1'b1, 1'b0, 1'b0, 16'h0A0B);
        apply_stimulus(w_k(8'hFD, 8'h01), 1'b0);
        check_output("f5_status", 1'b1, 1'b1, 1'b0, 16'h0001);

        // Exactly MAX_WORDS payload words pass; one more aborts.
        apply_stimulus(w_k(8'hFB, 8'h07), 1'b0);
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(w_d(8'(i), ~8'(i)), 1'b0);
            if (i == 0) check_output("max_first", 1'b1, 1'b0, 1'b0, 16'h00FF);
        end
        check_output("max_last", 1'b1, 1'b0, 1'b0, 16'hFF00);
        apply_stimulus(w_d(8'h77, 8'h77), 1'b0);
        check_output("max_overrun_abort", 1'b1, 1'b1, 1'b1, 16'h0000);
        apply_stimulus(w_k(8'hFD, 8'h00), 1'b0);
        check_output("max_eof_ignored", 1'b0, 1'b0, 1'b0, 16'h0);

        // Bad K combination aborts; SOF out of DROP starts a fresh frame (checksum 0F^F0 = FF).
        apply_stimulus(w_k(8'hFB, 8'h08), 1'b0);
        apply_stimulus(w_d(8'h21, 8'h43), 1'b0);
        apply_stimulus({39'h0, 1'b1, 8'h21, 7'h0, 1'b0, 8'h43}, 1'b0);
        check_output("badk_abort", 1'b1, 1'b1, 1'b1, 16'h0000);
        apply_stimulus(w_d(8'h99, 8'h99), 1'b0);
        check_output("drop_data_ignored", 1'b0, 1'b0, 1'b0, 16'h0);
        apply_stimulus(w_k(8'hFB, 8'h09), 1'b0);
        apply_stimulus(w_d(8'h0F, 8'hF0), 1'b0);
        check_output("drop_sof_d0", 1'b1, 1'b0, 1'b0, 16'h0FF0);
        apply_stimulus(w_k(8'hFD, 8'hFF), 1'b0);
        check_output("drop_sof_status", 1'b1, 1'b1, 1'b0, 16'h00FF);

        // Status word blocked by out_full is held until the FIFO has room.
        apply_stimulus(w_k(8'hFB, 8'h0A), 1'b0);
        apply_stimulus(w_d(8'h03, 8'h04), 1'b0);
        check_output("hold_d0", 1'b1, 1'b0, 1'b0, 16'h0304);
        apply_stimulus(w_k(8'hFD, 8'h07), 1'b1);
        check_output("hold_blocked", 1'b0, 1'b0, 1'b0, 16'h0);
        apply_gap(1'b0);
        check_output("hold_released", 1'b1, 1'b1, 1'b0, 16'h0007);
        apply_gap(1'b0);
        chk("mid_counts", {frame_cnt, err_cnt}, {16'd5, 16'd5});

        // Loss after LOSS_TIMEOUT cycles with no idle or SOF.
        apply_stimulus(idle_w, 1'b0);
        repeat (1023) apply_gap(1'b0);
        chk("loss_1023", {31'h0, link_up}, 32'h1);
        apply_gap(1'b0);
        chk("loss_1024", {31'h0, link_up}, 32'h0);
        apply_gap(1'b0);
        check_output("loss_idle_no_abort", 1'b0, 1'b0, 1'b0, 16'h0);

        // PCS overflow mid-frame: link drops that cycle, abort follows, frame logic back in HUNT.
        repeat (8) apply_stimulus(idle_w, 1'b0);
        chk("relock", {31'h0, link_up}, 32'h1);
        apply_stimulus(w_k(8'hFB, 8'h20), 1'b0);
        apply_stimulus(w_d(8'h01, 8'h02), 1'b0);
        check_output("pcs_d0", 1'b1, 1'b0, 1'b0, 16'h0102);
        @(negedge CLK);
        rx_std_pcfifo_empty = 1'b1;
        rx_std_pcfifo_full  = 1'b1;
        #1;
        chk("pcs_full_link", {31'h0, link_up}, 32'h0);
        @(posedge CLK);
        #1;
        rx_std_pcfifo_full = 1'b0;
        #1;
        check_output("pcs_full_abort", 1'b1, 1'b1, 1'b1, 16'h0000);
        apply_stimulus(w_k(8'hFB, 8'h21), 1'b0);
        check_output("pcs_sof_unlocked", 1'b0, 1'b0, 1'b0, 16'h0);
        apply_stimulus(w_d(8'h05, 8'h05), 1'b0);
        check_output("pcs_hunt_data", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("pcs_counts", {frame_cnt, err_cnt}, {16'd5, 16'd6});

        // Reset in the middle of a frame returns everything to idle, no abort word.
        repeat (8) apply_stimulus(idle_w, 1'b0);
        apply_stimulus(w_k(8'hFB, 8'h30), 1'b0);
        apply_stimulus(w_d(8'h05, 8'h06), 1'b0);
        check_output("rst_pre_d0", 1'b1, 1'b0, 1'b0, 16'h0506);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check_output("rst_mid_out", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("rst_mid_state", {13'h0, link_up, frame_cnt == 16'h0, err_cnt == 16'h0}, {13'h0, 3'b011});
`ifdef SFP_RX_SEQ_CHECK_EN
        chk("rst_seq_cnt", {16'h0, seq_err_cnt}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
